// File: rtl/trackball_emu.sv
// Trackball emulator: mouse deltas and joystick directions feed per-axis signed
// accumulators that drain one count per step tick into 8-bit position counters.
module trackball_emu #(
  parameter int unsigned STEP_DIV = 2500
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic signed [7:0] mouse_dx,
  input  logic signed [7:0] mouse_dy,
  input  logic              mouse_stb,
  input  logic              joy_up,
  input  logic              joy_down,
  input  logic              joy_left,
  input  logic              joy_right,
  input  logic [1:0]        joy_speed,
  input  logic              flip,
  output logic [7:0]        track_x,
  output logic [7:0]        track_y,
  output logic              active
);

  localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);

  logic [15:0]       pre_q;
  logic              tick;
  logic              s1_q, s2_q, s3_q;
  logic [1:0]        start_q;
  logic              mouse_edge;
  logic signed [9:0] acc_x_q, acc_y_q;
  logic signed [9:0] acc_x_d, acc_y_d;
  logic [7:0]        track_x_q, track_y_q;
  logic [7:0]        track_x_d, track_y_d;
  logic              active_q;
  logic signed [11:0] mx, my, jx, jy, sx, sy;
  logic signed [11:0] sum_x, sum_y;

  // Mouse delta widened before negation so that -(-128) is representable.
  function automatic logic signed [11:0] mouse_term(input logic signed [7:0] d,
                                                    input logic flp);
    logic signed [11:0] v;
    v = 12'(d);
    return flp ? -v : v;
  endfunction

  function automatic logic signed [11:0] joy_term(input logic pos, input logic neg,
                                                  input logic [1:0] spd,
                                                  input logic flp);
    logic signed [11:0] mag;
    logic signed [11:0] v;
    mag = $signed({10'd0, spd}) + 12'sd1;
    if (pos && !neg)      v = mag;
    else if (neg && !pos) v = -mag;
    else                  v = 12'sd0;
    return flp ? -v : v;
  endfunction

  function automatic logic signed [11:0] step_of(input logic signed [9:0] a);
    if (a > 10'sd0)      return 12'sd1;
    else if (a < 10'sd0) return -12'sd1;
    else                 return 12'sd0;
  endfunction

  function automatic logic signed [9:0] sat10(input logic signed [11:0] s);
    if (s > 12'sd511)       return 10'sd511;
    else if (s < -12'sd512) return -10'sd512;
    else                    return s[9:0];
  endfunction

  assign tick = (pre_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 16'd1;
  end

  // Startup counter masks the first edge when mouse_stb is already high at reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      start_q <= 2'd0;
    end else begin
      s1_q <= mouse_stb;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (start_q != 2'd3) start_q <= start_q + 2'd1;
    end
  end

  assign mouse_edge = (s2_q ^ s3_q) && (start_q == 2'd3);

  always_comb begin
    mx = mouse_term(mouse_dx, flip);
    my = mouse_term(mouse_dy, flip);
    jx = joy_term(joy_right, joy_left, joy_speed, flip);
    jy = joy_term(joy_up, joy_down, joy_speed, flip);
    sx = step_of(acc_x_q);
    sy = step_of(acc_y_q);

    sum_x = 12'(acc_x_q);
    sum_y = 12'(acc_y_q);
    if (mouse_edge) begin
      sum_x = sum_x + mx;
      sum_y = sum_y + my;
    end
    if (tick) begin
      sum_x = sum_x + jx - sx;
      sum_y = sum_y + jy - sy;
    end
    acc_x_d = sat10(sum_x);
    acc_y_d = sat10(sum_y);

    track_x_d = track_x_q;
    track_y_d = track_y_q;
    if (tick) begin
      track_x_d = track_x_q + sx[7:0];
      track_y_d = track_y_q + sy[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      track_x_q <= '0;
      track_y_q <= '0;
      active_q  <= 1'b0;
    end else begin
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      track_x_q <= track_x_d;
      track_y_q <= track_y_d;
      active_q  <= (acc_x_d != 10'sd0) || (acc_y_d != 10'sd0);
    end
  end

  assign track_x = track_x_q;
  assign track_y = track_y_q;
  assign active  = active_q;

endmodule
